vga_rx_decoder: RTL and testbench



---
 rtl/vga_rx_decoder.sv | 138 +++++++++++++
 tb/tb_vga_rx_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_decoder.sv
// vga_rx_decoder: VGA sink that locks to sync timing, flags h/v errors and emits pixel coordinates/colour.
// Optional frame CRC-16-CCITT outputs are enabled by defining VGA_RX_FRAME_CRC_EN.
module vga_rx_decoder #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_ACT = 1'b0,
  parameter int BITS_R   = 4,
  parameter int BITS_G   = 4,
  parameter int BITS_B   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pix_en,
  input  logic              i_vga_h_sync,
  input  logic              i_vga_v_sync,
  input  logic [BITS_R-1:0] i_vga_r,
  input  logic [BITS_G-1:0] i_vga_g,
  input  logic [BITS_B-1:0] i_vga_b,
  output logic              o_pix_valid,
  output logic [9:0]        o_x,
  output logic [9:0]        o_y,
  output logic [BITS_R-1:0] o_r,
  output logic [BITS_G-1:0] o_g,
  output logic [BITS_B-1:0] o_b,
  output logic              o_frame_start,
  output logic              o_h_err,
  output logic              o_v_err,
  output logic              o_locked
`ifdef VGA_RX_FRAME_CRC_EN
  ,
  output logic [15:0]       o_frame_crc,
  output logic              o_crc_valid
`endif
);
  localparam logic [10:0] CMAX   = '1;
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_LO   = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_HI   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_LO   = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_HI   = 11'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  state_t state, state_n;
  logic h_prev, v_prev, v_seen, first_h;
  logic [10:0] h_cnt, v_cnt, h_cnt_n, v_cnt_n;
  logic h_edge, v_edge, v_rst, h_err, v_err, pix, fs, last;

  always_comb begin
    h_edge  = i_pix_en && i_vga_h_sync == SYNC_ACT && h_prev != SYNC_ACT;
    v_edge  = i_pix_en && i_vga_v_sync == SYNC_ACT && v_prev != SYNC_ACT;
    v_rst   = h_edge && (v_edge || v_seen);
    h_err   = h_edge && state != SEARCH && !first_h && h_cnt != H_LAST;
    v_err   = v_rst && state != SEARCH && v_cnt != V_LAST;
    h_cnt_n = !i_pix_en ? h_cnt : h_edge ? 11'd0 : h_cnt + 11'(h_cnt != CMAX);
    v_cnt_n = !h_edge ? v_cnt : v_rst ? 11'd0 : v_cnt + 11'(v_cnt != CMAX);
    state_n = state == SEARCH ? (v_edge ? TRACK : SEARCH) :
              (h_err || v_err) ? SEARCH :
              (state == TRACK && v_rst) ? LOCKED : state;
    pix     = i_pix_en && state_n == LOCKED && h_cnt_n >= H_LO && h_cnt_n < H_HI &&
              v_cnt_n >= V_LO && v_cnt_n < V_HI;
    fs      = pix && h_cnt_n == H_LO && v_cnt_n == V_LO;
    last    = pix && h_cnt_n == H_HI - 11'd1 && v_cnt_n == V_HI - 11'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SEARCH;
      h_prev        <= !SYNC_ACT;
      v_prev        <= !SYNC_ACT;
      v_seen        <= 1'b0;
      first_h       <= 1'b1;
      h_cnt         <= '0;
      v_cnt         <= '0;
      o_pix_valid   <= 1'b0;
      o_frame_start <= 1'b0;
      o_h_err       <= 1'b0;
      o_v_err       <= 1'b0;
      o_locked      <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_r           <= '0;
      o_g           <= '0;
      o_b           <= '0;
    end else begin
      state         <= state_n;
      h_cnt         <= h_cnt_n;
      v_cnt         <= v_cnt_n;
      o_pix_valid   <= pix;
      o_frame_start <= fs;
      o_h_err       <= h_err;
      o_v_err       <= v_err;
      o_locked      <= state_n == LOCKED;
      if (i_pix_en) begin
        h_prev  <= i_vga_h_sync;
        v_prev  <= i_vga_v_sync;
        v_seen  <= h_edge ? 1'b0 : v_seen | v_edge;
        first_h <= state == SEARCH || (first_h && !h_edge);
      end
      // coordinates and colour only move on delivered pixels, otherwise they hold
      if (pix) begin
        o_x <= 10'(h_cnt_n - H_LO);
        o_y <= 10'(v_cnt_n - V_LO);
        o_r <= i_vga_r;
        o_g <= i_vga_g;
        o_b <= i_vga_b;
      end
    end
  end

`ifdef VGA_RX_FRAME_CRC_EN
  logic [BITS_R+BITS_G+BITS_B-1:0] pdat;
  logic [15:0] crc_n;

  always_comb begin
    pdat  = {i_vga_r, i_vga_g, i_vga_b};
    crc_n = fs ? 16'hFFFF : o_frame_crc;
    for (int i = BITS_R + BITS_G + BITS_B - 1; i >= 0; i--)
      crc_n = {crc_n[14:0], 1'b0} ^ ((crc_n[15] ^ pdat[i]) ? 16'h1021 : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_frame_crc <= '0;
      o_crc_valid <= 1'b0;
    end else begin
      o_crc_valid <= last;
      if (pix) o_frame_crc <= crc_n;
    end
  end
`endif
endmodule

// File: tb/tb_vga_rx_decoder.sv
// tb_vga_rx_decoder: drives a small-geometry VGA raster and checks against a line/frame level model.
// CRC checks are included when VGA_RX_FRAME_CRC_EN is defined.
module tb_vga_rx_decoder;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int XO = HS + HB, YO = VS + VB;

  logic clk = 1'b0, rst, pix_en, hs, vs;
  logic [3:0] r, g, b, o_r, o_g, o_b;
  logic o_pix_valid, o_frame_start, o_h_err, o_v_err, o_locked;
  logic [9:0] o_x, o_y;
`ifdef VGA_RX_FRAME_CRC_EN
  logic [15:0] o_frame_crc, crc_m, crc_a;
  logic o_crc_valid;
`endif

  int checks = 0, errors = 0;
  int lvl = 0, line_ticks = 0, frame_lines = 0;
  bit first = 1;
  int ex = 0, ey = 0;
  logic [11:0] ep = '0, pv = '0;
  int pr = -1, pc = -1;
  int vcount, fscount, hecount, vecount;

  always #5 clk = ~clk;

  vga_rx_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACT(1'b0), .BITS_R(4), .BITS_G(4), .BITS_B(4)
  ) dut (
    .clk(clk), .rst(rst), .i_pix_en(pix_en), .i_vga_h_sync(hs), .i_vga_v_sync(vs),
    .i_vga_r(r), .i_vga_g(g), .i_vga_b(b),
    .o_pix_valid(o_pix_valid), .o_x(o_x), .o_y(o_y), .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_frame_start(o_frame_start), .o_h_err(o_h_err), .o_v_err(o_v_err), .o_locked(o_locked)
`ifdef VGA_RX_FRAME_CRC_EN
    , .o_frame_crc(o_frame_crc), .o_crc_valid(o_crc_valid)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

`ifdef VGA_RX_FRAME_CRC_EN
  function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
    c = c ^ {d, 4'h0};
    for (int i = 0; i < 12; i++) c = c[15] ? (c << 1) ^ 16'h1021 : c << 1;
    return c;
  endfunction
`endif

  task automatic chk_idle();
    chk("idle_valid", o_pix_valid, 0);
    chk("idle_fs", o_frame_start, 0);
    chk("idle_herr", o_h_err, 0);
    chk("idle_verr", o_v_err, 0);
    chk("idle_locked", o_locked, lvl == 2);
    chk("idle_x", o_x, ex);
    chk("idle_y", o_y, ey);
    chk("idle_rgb", {o_r, o_g, o_b}, ep);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lvl = 0; first = 1; ex = 0; ey = 0; ep = '0;
    chk_idle();
`ifdef VGA_RX_FRAME_CRC_EN
    chk("rst_crc", o_frame_crc, 0);
    chk("rst_crc_valid", o_crc_valid, 0);
`endif
  endtask

  // one pixel tick followed by three idle clocks; the model works on line and frame events
  task automatic tick(input int row, input int col, input logic [11:0] p);
    bit herr, verr, act, fs;
    herr = 0; verr = 0;
    if (col == 0) begin
      if (row == 0) begin
        verr = lvl > 0 && frame_lines != VT;
        frame_lines = 0;
      end
      herr = lvl > 0 && !first && line_ticks != HT;
      if (lvl == 0) begin
        if (row == 0) lvl = 1;
        first = 1;
      end else begin
        first = 0;
        if (herr || verr) lvl = 0;
        else if (row == 0 && lvl == 1) lvl = 2;
      end
      frame_lines++;
      line_ticks = 0;
    end
    line_ticks++;
    act = lvl == 2 && col >= XO && col < XO + HA && row >= YO && row < YO + VA;
    fs = act && col == XO && row == YO;
    if (act) begin
      ex = col - XO; ey = row - YO; ep = p;
`ifdef VGA_RX_FRAME_CRC_EN
      crc_m = crc12(fs ? 16'hFFFF : crc_m, p);
`endif
    end
    pix_en = 1'b1;
    hs = (col < HS) ? 1'b0 : 1'b1;
    vs = (row < VS) ? 1'b0 : 1'b1;
    {r, g, b} = p;
    @(negedge clk);
    pix_en = 1'b0;
    chk("valid", o_pix_valid, act);
    chk("frame_start", o_frame_start, fs);
    chk("h_err", o_h_err, herr);
    chk("v_err", o_v_err, verr);
    chk("locked", o_locked, lvl == 2);
    chk("x", o_x, ex);
    chk("y", o_y, ey);
    chk("rgb", {o_r, o_g, o_b}, ep);
`ifdef VGA_RX_FRAME_CRC_EN
    chk("crc_valid", o_crc_valid, act && col == XO + HA - 1 && row == YO + VA - 1);
    if (act && col == XO + HA - 1 && row == YO + VA - 1) chk("crc", o_frame_crc, crc_m);
`endif
    vcount += int'(o_pix_valid);
    fscount += int'(o_frame_start);
    hecount += int'(o_h_err);
    vecount += int'(o_v_err);
    repeat (3) begin
      @(negedge clk);
      chk_idle();
`ifdef VGA_RX_FRAME_CRC_EN
      chk("idle_crc_valid", o_crc_valid, 0);
`endif
    end
  endtask

  task automatic frame(input int nlines, input int short_row, input int rst_row, input bit zero);
    vcount = 0; fscount = 0; hecount = 0; vecount = 0;
    for (int row = 0; row < nlines; row++)
      for (int col = 0; col < ((row == short_row) ? HT - 1 : HT); col++) begin
        logic [11:0] p;
        if (row == rst_row && col == 7) do_rst();
        p = zero ? 12'h000 : 12'($urandom);
        if (row == pr && col == pc) p = pv;
        tick(row, col, p);
      end
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; hs = 1'b1; vs = 1'b1; {r, g, b} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_idle();
    frame(VT, -1, -1, 0);
    chk("track_not_locked", o_locked, 0);
    frame(VT, -1, -1, 0);
    chk("locked_after_2", o_locked, 1);
    pr = YO; pc = XO; pv = 12'hF0A;
    frame(VT, -1, -1, 0);
    pr = -1;
    chk("frame3_valid_count", vcount, HA * VA);
    chk("frame3_fs_count", fscount, 1);
    frame(VT, 5, -1, 0);
    chk("short_line_herr_count", hecount, 1);
    chk("short_line_unlocked", o_locked, 0);
    frame(VT, -1, -1, 0);
    frame(VT, -1, -1, 0);
    chk("relock_after_herr", o_locked, 1);
    chk("relock_fs_count", fscount, 1);
    frame(VT - 1, -1, -1, 0);
    frame(VT, -1, -1, 0);
    chk("short_frame_verr_count", vecount, 1);
    chk("short_frame_search", o_locked, 0);
    chk("short_frame_no_pixels", vcount, 0);
    frame(VT, -1, -1, 0);
    frame(VT, -1, -1, 0);
    chk("relock_after_verr", o_locked, 1);
    frame(VT, -1, 3, 0);
    chk("rst_frame_no_pixels", vcount, 0);
    frame(VT, -1, -1, 0);
    chk("after_rst_track_no_pixels", vcount, 0);
    frame(VT, -1, -1, 0);
    chk("after_rst_relock_pixels", vcount, HA * VA);
    chk("after_rst_relock_fs", fscount, 1);
`ifdef VGA_RX_FRAME_CRC_EN
    frame(VT, -1, -1, 1);
    crc_a = crc_m;
    pr = YO + 2; pc = XO + 3; pv = 12'h001;
    frame(VT, -1, -1, 1);
    pr = -1;
    chk("crc_flip_differs", crc_a != crc_m, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
